// File: rtl/display_scanner_if.sv
// Bus between the scanner and its host/decoder: latched display inputs and per-digit drive outputs.
interface display_scanner_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  digit_data;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output value, dp_in, blank_lz,
    input  digit_data, dp_out, an, frame_tick
  );

  modport slave (
    input  value, dp_in, blank_lz,
    output digit_data, dp_out, an, frame_tick
  );
endinterface

// File: rtl/display_scanner.sv
// 4-digit seven-segment scanner: per-frame input latch, per-digit dwell with anode-off guard.
// Outputs decode from registered state only; there is no backpressure, and input changes take effect next frame.
module display_scanner #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic              clk,
  input  logic              reset,
  display_scanner_if.slave  bus
);
  localparam int CW = $clog2(TICKS_PER_DIGIT);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_DIGIT - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   sh_val;
  logic [3:0]    sh_dp;
  logic          sh_lz;
  logic          ft_q;
  logic          last;
  logic          guard;
  logic [3:0]    lzb;
  logic          z3, z2, z1;

  assign last = (cnt == LAST);

  generate
    if (BLANK_TICKS == 0) begin : g_noguard
      assign guard = 1'b0;
    end else begin : g_guard
      assign guard = (cnt < CW'(BLANK_TICKS));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= 2'd0;
      ft_q   <= 1'b0;
      sh_val <= bus.value;
      sh_dp  <= bus.dp_in;
      sh_lz  <= bus.blank_lz;
    end else begin
      ft_q <= last && (idx == 2'd3);
      if (last) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (last && (idx == 2'd3)) begin
        sh_val <= bus.value;
        sh_dp  <= bus.dp_in;
        sh_lz  <= bus.blank_lz;
      end
    end
  end

  // A digit is a blankable leading zero only if every digit above it is too;
  // a requested decimal point anywhere at or above it keeps it visible.
  assign z3  = sh_lz & (sh_val[15:12] == 4'd0) & ~sh_dp[3];
  assign z2  = z3 & (sh_val[11:8] == 4'd0) & ~sh_dp[2];
  assign z1  = z2 & (sh_val[7:4] == 4'd0) & ~sh_dp[1];
  assign lzb = {z3, z2, z1, 1'b0};

  assign bus.digit_data = sh_val[{idx, 2'b00} +: 4];
  assign bus.dp_out     = sh_dp[idx] & ~guard & ~lzb[idx];
  assign bus.an         = (guard | lzb[idx]) ? 4'b1111 : ~(4'b0001 << idx);
  assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with TICKS_PER_DIGIT=8, BLANK_TICKS=2.
module tb_display_scanner;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  display_scanner_if bif ();

  display_scanner #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Hand-written per-slot expectations for the frame being checked.
  logic [3:0] exp_an  [4];
  logic [3:0] exp_dat [4];
  logic       exp_dp  [4];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ans/dats: slot 3 in the top nibble ... slot 0 in the bottom nibble; dps bit i = slot i.
  task automatic set_exp(input logic [15:0] ans, input logic [15:0] dats, input logic [3:0] dps);
    for (int i = 0; i < 4; i++) begin
      exp_an[i]  = ans[4*i +: 4];
      exp_dat[i] = dats[4*i +: 4];
      exp_dp[i]  = dps[i];
    end
  endtask

  // Checks frame cycles k0..k1-1, ticking after each; frame_tick expected only at k=0.
  task automatic run_cycles(input int k0, input int k1, input bit first);
    for (int k = k0; k < k1; k++) begin
      int s;
      int c;
      s = k / 8;
      c = k % 8;
      chk($sformatf("an k=%0d", k), {12'd0, bif.an}, {12'd0, (c < 2) ? 4'b1111 : exp_an[s]});
      chk($sformatf("data k=%0d", k), {12'd0, bif.digit_data}, {12'd0, exp_dat[s]});
      chk($sformatf("dp k=%0d", k), {15'd0, bif.dp_out}, {15'd0, (c >= 2) && exp_dp[s]});
      chk($sformatf("ftick k=%0d", k), {15'd0, bif.frame_tick}, {15'd0, (k == 0) && !first});
      tick();
    end
  endtask

  initial begin
    reset        = 1'b1;
    bif.value    = 16'h1234;
    bif.dp_in    = 4'b0000;
    bif.blank_lz = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst an", {12'd0, bif.an}, 16'h000F);
      chk("rst data", {12'd0, bif.digit_data}, 16'h0004);
      chk("rst dp", {15'd0, bif.dp_out}, 16'h0000);
      chk("rst ftick", {15'd0, bif.frame_tick}, 16'h0000);
      tick();
    end
    reset = 1'b0;

    // Scan order, no tick in the first cycle after release.
    set_exp(16'h7BDE, 16'h1234, 4'b0000);
    run_cycles(0, 32, 1'b1);

    // Mid-frame input change stays invisible until the next frame.
    run_cycles(0, 8, 1'b0);
    bif.value = 16'hABCD;
    run_cycles(8, 32, 1'b0);

    set_exp(16'h7BDE, 16'hABCD, 4'b0000);
    bif.value    = 16'h0050;
    bif.blank_lz = 1'b1;
    run_cycles(0, 32, 1'b0);

    // Leading zeros blanked above digit 1.
    set_exp(16'hFFDE, 16'h0050, 4'b0000);
    bif.value = 16'h0000;
    run_cycles(0, 32, 1'b0);

    // All zero: only digit 0 lights.
    set_exp(16'hFFFE, 16'h0000, 4'b0000);
    bif.value = 16'h0005;
    bif.dp_in = 4'b0100;
    run_cycles(0, 32, 1'b0);

    // Decimal point on digit 2 keeps digits 2 and 1 visible.
    set_exp(16'hFBDE, 16'h0005, 4'b0100);
    bif.value    = 16'h1234;
    bif.dp_in    = 4'b0000;
    bif.blank_lz = 1'b0;
    run_cycles(0, 21, 1'b0);

    // One-cycle reset at idx=2, cnt=5.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst an", {12'd0, bif.an}, 16'h000F);
    chk("midrst ftick", {15'd0, bif.frame_tick}, 16'h0000);
    chk("midrst data", {12'd0, bif.digit_data}, 16'h0004);
    set_exp(16'h7BDE, 16'h1234, 4'b0000);
    run_cycles(0, 32, 1'b1);
    run_cycles(0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
